// File: rtl/pc_sequencer.sv
// Fetch/PC sequencer: fetches over a req/ack handshake, holds the word for the decoder and commits the next PC on retire.
// Optional build macro PC_SEQ_ALIGN_CHK_EN: halt with a sticky misaligned flag instead of silently aligning the committed PC.
module pc_sequencer #(
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(32'h0040_0000)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       ins,
  output logic              ins_valid,
  input  logic [1:0]        pc_inc,
  input  logic              pc_jump,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] reg_rs_data,
  input  logic              ex_done,
  input  logic              resume,
  input  logic              resume_to_reset,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              halted,
  output logic              misaligned
);

  localparam int unsigned INS_W = 32;

  localparam logic [1:0] INC_STOP   = 2'b00;
  localparam logic [1:0] INC_NORMAL = 2'b01;
  localparam logic [1:0] INC_BRANCH = 2'b10;
  localparam logic [1:0] INC_JUMP   = 2'b11;

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_WAIT  = 2'b01,
    S_EXEC  = 2'b10,
    S_HALT  = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_plus4_q, pc_plus4_d;
  logic [INS_W-1:0]  ins_q, ins_d;
  logic              ins_valid_q, ins_valid_d;
  logic              imem_req_q, imem_req_d;
  logic              halted_q, halted_d;
  logic              misaligned_q, misaligned_d;

  logic [ADDR_W-1:0] branch_off;
  logic [ADDR_W-1:0] next_pc;

  // Target of the held instruction, from the decoder fields and branch flag
  always_comb begin
    branch_off = ADDR_W'($signed({ins_q[15:0], 2'b00}));
    next_pc    = pc_plus4_q;
    case (pc_inc)
      INC_NORMAL: next_pc = pc_plus4_q;
      INC_BRANCH: next_pc = branch_taken ? (pc_plus4_q + branch_off) : pc_plus4_q;
      INC_JUMP:   next_pc = pc_jump ? reg_rs_data
                                    : {pc_plus4_q[ADDR_W-1:28], ins_q[25:0], 2'b00};
      default:    next_pc = pc_plus4_q;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ins_d        = ins_q;
    ins_valid_d  = ins_valid_q;
    imem_req_d   = imem_req_q;
    halted_d     = halted_q;
    misaligned_d = misaligned_q;

    case (state_q)
      S_FETCH: begin
        imem_req_d = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (imem_ack) begin
          ins_d       = imem_rdata;
          imem_req_d  = 1'b0;
          ins_valid_d = 1'b1;
          state_d     = S_EXEC;
        end
      end
      S_EXEC: begin
        // STOP takes priority over a retire in the same cycle
        if (pc_inc == INC_STOP) begin
          ins_valid_d = 1'b0;
          halted_d    = 1'b1;
          state_d     = S_HALT;
        end else if (ex_done) begin
          ins_valid_d = 1'b0;
`ifdef PC_SEQ_ALIGN_CHK_EN
          if (next_pc[1:0] != 2'b00) begin
            halted_d     = 1'b1;
            misaligned_d = 1'b1;
            state_d      = S_HALT;
          end else begin
            pc_d    = next_pc;
            state_d = S_FETCH;
          end
`else
          pc_d    = next_pc & ~ADDR_W'(3);
          state_d = S_FETCH;
`endif
        end
      end
      S_HALT: begin
        if (resume) begin
          pc_d     = resume_to_reset ? RESET_PC : pc_plus4_q;
          halted_d = 1'b0;
          state_d  = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase

    pc_plus4_d = pc_d + ADDR_W'(4);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      pc_plus4_q   <= RESET_PC + ADDR_W'(4);
      ins_q        <= '0;
      ins_valid_q  <= 1'b0;
      imem_req_q   <= 1'b0;
      halted_q     <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_plus4_q   <= pc_plus4_d;
      ins_q        <= ins_d;
      ins_valid_q  <= ins_valid_d;
      imem_req_q   <= imem_req_d;
      halted_q     <= halted_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign ins        = ins_q;
  assign ins_valid  = ins_valid_q;
  assign pc         = pc_q;
  assign pc_plus4   = pc_plus4_q;
  assign halted     = halted_q;
  assign misaligned = misaligned_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then randomized instruction streams against a transaction-level PC model.
module tb_pc_sequencer;

  localparam int unsigned ADDR_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] ins;
  logic        ins_valid;
  logic [1:0]  pc_inc = 2'b01;
  logic        pc_jump = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] reg_rs_data = 32'h0;
  logic        ex_done = 1'b0;
  logic        resume = 1'b0;
  logic        resume_to_reset = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;
  logic        misaligned;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] cur_ins = 32'h0;
  logic        exp_mis = 1'b0;
  logic        exp_halt = 1'b0;

  pc_sequencer #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ins(ins), .ins_valid(ins_valid),
    .pc_inc(pc_inc), .pc_jump(pc_jump), .branch_taken(branch_taken), .reg_rs_data(reg_rs_data),
    .ex_done(ex_done), .resume(resume), .resume_to_reset(resume_to_reset),
    .pc(pc), .pc_plus4(pc_plus4), .halted(halted), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural next PC computed with plain arithmetic
  function automatic logic [31:0] model_next(input logic [1:0] inc, input logic jmp, input logic bt,
                                             input logic [31:0] rs, input logic [31:0] cpc,
                                             input logic [31:0] word);
    int off;
    off = int'($signed(word[15:0])) * 4;
    case (inc)
      2'b01:   return cpc + 32'd4;
      2'b10:   return bt ? cpc + 32'd4 + 32'(off) : cpc + 32'd4;
      2'b11:   return jmp ? rs : (((cpc + 32'd4) & 32'hF000_0000) | (32'(word[25:0]) * 32'd4));
      default: return cpc;
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; imem_ack = 1'b0; ex_done = 1'b0; resume = 1'b0; pc_inc = 2'b01;
    step(); step();
    chk("rst_pc", pc, RESET_PC);
    chk("rst_pc_plus4", pc_plus4, RESET_PC + 32'd4);
    chk("rst_ins", ins, 32'h0);
    chk("rst_ins_valid", 32'(ins_valid), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_misaligned", 32'(misaligned), 32'd0);
    rst_n = 1'b1;
    exp_pc = RESET_PC; exp_mis = 1'b0; exp_halt = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] word, input int delay);
    int n = 0;
    while (imem_req !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    chk("fetch_latency", 32'(n), 32'd1);
    chk("fetch_req", 32'(imem_req), 32'd1);
    chk("fetch_addr", imem_addr, exp_pc);
    for (int i = 0; i < delay; i++) begin
      step();
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", imem_addr, exp_pc);
      chk("wait_valid", 32'(ins_valid), 32'd0);
    end
    imem_ack = 1'b1; imem_rdata = word;
    step();
    imem_ack = 1'b0; imem_rdata = $urandom;
    cur_ins = word;
    chk("exec_valid", 32'(ins_valid), 32'd1);
    chk("exec_ins", ins, word);
    chk("exec_req_drop", 32'(imem_req), 32'd0);
    chk("exec_pc", pc, exp_pc);
    chk("exec_pc_plus4", pc_plus4, exp_pc + 32'd4);
  endtask

  task automatic exec_ins(input logic [1:0] inc, input logic jmp, input logic bt,
                          input logic [31:0] rs, input int delay);
    logic [31:0] nxt;
    pc_inc = inc; pc_jump = jmp; branch_taken = bt; reg_rs_data = rs;
    if (inc == 2'b00) begin
      ex_done = 1'($urandom_range(0, 1));
      step();
      ex_done = 1'b0; pc_inc = 2'b01;
      exp_halt = 1'b1;
      chk("stop_halted", 32'(halted), 32'd1);
      chk("stop_valid", 32'(ins_valid), 32'd0);
      chk("stop_req", 32'(imem_req), 32'd0);
      chk("stop_pc", pc, exp_pc);
      chk("stop_ins", ins, cur_ins);
      return;
    end
    for (int i = 0; i < delay; i++) begin
      ex_done = 1'b0;
      imem_ack = 1'($urandom_range(0, 1));
      resume = 1'($urandom_range(0, 1));
      step();
      chk("hold_valid", 32'(ins_valid), 32'd1);
      chk("hold_pc", pc, exp_pc);
      chk("hold_ins", ins, cur_ins);
    end
    imem_ack = 1'b0; resume = 1'b0; ex_done = 1'b1;
    step();
    ex_done = 1'b0;
    nxt = model_next(inc, jmp, bt, rs, exp_pc, cur_ins);
`ifdef PC_SEQ_ALIGN_CHK_EN
    if (nxt[1:0] != 2'b00) begin
      exp_mis = 1'b1; exp_halt = 1'b1;
      chk("mis_halted", 32'(halted), 32'd1);
      chk("mis_flag", 32'(misaligned), 32'd1);
      chk("mis_pc", pc, exp_pc);
      chk("mis_valid", 32'(ins_valid), 32'd0);
      return;
    end
`else
    nxt = nxt & ~32'd3;
`endif
    exp_pc = nxt;
    chk("commit_pc", pc, exp_pc);
    chk("commit_pc_plus4", pc_plus4, exp_pc + 32'd4);
    chk("commit_valid", 32'(ins_valid), 32'd0);
    chk("commit_req", 32'(imem_req), 32'd0);
    chk("commit_halted", 32'(halted), 32'd0);
    chk("commit_mis", 32'(misaligned), 32'(exp_mis));
  endtask

  task automatic do_resume(input logic rtr, input int idle);
    for (int i = 0; i < idle; i++) begin
      imem_ack = 1'($urandom_range(0, 1));
      step();
      chk("halt_req", 32'(imem_req), 32'd0);
      chk("halt_flag", 32'(halted), 32'd1);
      chk("halt_valid", 32'(ins_valid), 32'd0);
    end
    imem_ack = 1'b0; resume = 1'b1; resume_to_reset = rtr;
    step();
    resume = 1'b0;
    exp_pc = rtr ? RESET_PC : exp_pc + 32'd4;
    exp_halt = 1'b0;
    chk("resume_halted", 32'(halted), 32'd0);
    chk("resume_pc", pc, exp_pc);
    chk("resume_pc_plus4", pc_plus4, exp_pc + 32'd4);
    chk("resume_mis", 32'(misaligned), 32'(exp_mis));
  endtask

  initial begin
    logic [31:0] pre;
    logic [1:0]  inc;
    logic [31:0] rs;
    int          r;

    do_reset();

    // Straight-line ADDI stream
    fetch(32'h2008_0001, 0);
    exec_ins(2'b01, 1'b0, 1'b0, 32'h0, 0);
    chk("t1_pc1", pc, 32'h0040_0004);
    for (int i = 0; i < 3; i++) begin
      fetch(32'h2008_0001, 0);
      exec_ins(2'b01, 1'b0, 1'b0, 32'h0, 0);
    end
    chk("t1_pc4", pc, 32'h0040_0010);

    // Backward branch taken / untaken
    fetch(32'h1000_FFFE, 0);
    exec_ins(2'b10, 1'b0, 1'b1, 32'h0, 1);
    chk("t2_taken", pc, 32'h0040_000C);
    fetch(32'h2008_0001, 0);
    exec_ins(2'b01, 1'b0, 1'b0, 32'h0, 0);
    fetch(32'h1000_FFFE, 0);
    exec_ins(2'b10, 1'b0, 1'b0, 32'h0, 0);
    chk("t2_untaken", pc, 32'h0040_0014);

    // J and JR
    do_reset();
    fetch({6'h02, 26'h010_0020}, 0);
    exec_ins(2'b11, 1'b0, 1'b0, 32'h0, 0);
    chk("t3_j", pc, 32'h0040_0080);
    fetch(32'h0000_0008, 1);
    exec_ins(2'b11, 1'b1, 1'b0, 32'h0040_0100, 0);
    chk("t3_jr", pc, 32'h0040_0100);

    // STOP, then resume to pc+4
    fetch(32'h0000_0008, 0);
    exec_ins(2'b11, 1'b1, 1'b0, 32'h0040_0020, 0);
    fetch(32'hFFFF_FFFF, 0);
    exec_ins(2'b00, 1'b0, 1'b0, 32'h0, 0);
    chk("t4_halted", 32'(halted), 32'd1);
    do_resume(1'b0, 3);
    chk("t4_resume_pc", pc, 32'h0040_0024);

    // Slow memory, then reset in the middle of a wait
    fetch(32'h2008_0001, 5);
    exec_ins(2'b01, 1'b0, 1'b0, 32'h0, 0);
    step();
    chk("t5_req_up", 32'(imem_req), 32'd1);
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    chk("t5_async_req", 32'(imem_req), 32'd0);
    chk("t5_async_pc", pc, RESET_PC);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0; rst_n = 1'b1;
    exp_pc = RESET_PC; exp_mis = 1'b0; exp_halt = 1'b0;
    chk("t5_late_ack_valid", 32'(ins_valid), 32'd0);
    chk("t5_late_ack_ins", ins, 32'h0);

    // Misaligned JR target
    fetch(32'h0000_0008, 0);
    pre = exp_pc;
    exec_ins(2'b11, 1'b1, 1'b0, 32'h0040_0102, 0);
`ifdef PC_SEQ_ALIGN_CHK_EN
    chk("t6_halted", 32'(halted), 32'd1);
    chk("t6_misaligned", 32'(misaligned), 32'd1);
    chk("t6_pc_held", pc, pre);
    do_resume(1'b1, 1);
`else
    chk("t6_aligned_pc", pc, 32'h0040_0100);
    chk("t6_no_flag", 32'(misaligned), 32'd0);
`endif

    // Wrap at the top of the address space
    fetch(32'h0000_0008, 0);
    exec_ins(2'b11, 1'b1, 1'b0, 32'hFFFF_FFFC, 0);
    fetch(32'h2008_0001, 0);
    exec_ins(2'b01, 1'b0, 1'b0, 32'h0, 0);
    chk("wrap_pc", pc, 32'h0);

    // Randomized instruction streams
    for (int k = 0; k < 150; k++) begin
      fetch($urandom, int'($urandom_range(0, 3)));
      r = int'($urandom_range(0, 9));
      if (r == 0)      inc = 2'b00;
      else if (r < 4)  inc = 2'b01;
      else if (r < 7)  inc = 2'b10;
      else             inc = 2'b11;
      rs = $urandom;
      if ($urandom_range(0, 3) != 0) rs[1:0] = 2'b00;
      exec_ins(inc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rs,
               int'($urandom_range(0, 2)));
      if (exp_halt) do_resume(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    chk("final_misaligned", 32'(misaligned), 32'(exp_mis));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
